// File: rtl/ks16_pkg.sv
// Shared types and constants for the 16-bit Kogge-Stone subtractor pipeline.
package ks16_pkg;

  localparam int KS_WIDTH  = 16;
  localparam int KS_LEVELS = 4;

  typedef struct packed {
    logic [KS_WIDTH-1:0] g;
    logic [KS_WIDTH-1:0] p;
  } ks_gp_t;

  // p0 keeps the bitwise propagate; gp.p gets overwritten by the prefix rows.
  typedef struct packed {
    ks_gp_t              gp;
    logic [KS_WIDTH-1:0] p0;
    logic                cin;
    logic                a_msb;
    logic                bx_msb;
  } ks_s1_t;

endpackage

// File: rtl/ks16_prefix_level.sv
// One Kogge-Stone prefix row: each bit at or above SPAN merges with the group SPAN bits below it.
module ks16_prefix_level
  import ks16_pkg::*;
#(
  parameter int SPAN = 1
) (
  input  ks_gp_t gp_i,
  output ks_gp_t gp_o
);

  always_comb begin
    gp_o = gp_i;
    for (int i = SPAN; i < KS_WIDTH; i++) begin
      gp_o.g[i] = gp_i.g[i] | (gp_i.p[i] & gp_i.g[i-SPAN]);
      gp_o.p[i] = gp_i.p[i] & gp_i.p[i-SPAN];
    end
  end

endmodule

// File: rtl/ks16_sub_pipe.sv
// Two-stage pipelined 16-bit Kogge-Stone subtractor (diff = a - b - bin) with valid/ready on both sides.
// Optional diff saturation on signed overflow when KS16_SUB_SAT_EN is defined.
module ks16_sub_pipe
  import ks16_pkg::*;
#(
  parameter int WIDTH = KS_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             zero
);

  localparam int LEVELS = KS_LEVELS;
  localparam int HALF   = LEVELS / 2;

  logic             s1_valid_q, s1_valid_d;
  ks_s1_t           s1_data_q, s1_data_d;
  logic             s2_valid_q, s2_valid_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic s1_adv, s2_adv;

  assign s2_adv   = ~s2_valid_q | out_ready;
  assign s1_adv   = ~s1_valid_q | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: invert b into the generate/propagate network, borrow-in becomes carry-in.
  logic [WIDTH-1:0] bx;
  logic             cin;
  ks_gp_t           gp_s1 [0:HALF];

  assign bx       = b ^ {WIDTH{1'b1}};
  assign cin      = ~bin;
  assign gp_s1[0].g = a & bx;
  assign gp_s1[0].p = a ^ bx;

  for (genvar lv = 0; lv < HALF; lv++) begin : g_s1_lvl
    ks16_prefix_level #(.SPAN(1 << lv)) u_lvl (
      .gp_i (gp_s1[lv]),
      .gp_o (gp_s1[lv+1])
    );
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    if (s1_adv) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d.gp     = gp_s1[HALF];
        s1_data_d.p0     = a ^ bx;
        s1_data_d.cin    = cin;
        s1_data_d.a_msb  = a[WIDTH-1];
        s1_data_d.bx_msb = bx[WIDTH-1];
      end
    end
  end

  // Stage 2: remaining prefix rows, carries and result flags.
  ks_gp_t           gp_s2 [0:LEVELS-HALF];
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] diff_wrap;
  logic [WIDTH-1:0] diff_res;
  logic             ovf_res;

  assign gp_s2[0] = s1_data_q.gp;

  for (genvar lv = HALF; lv < LEVELS; lv++) begin : g_s2_lvl
    ks16_prefix_level #(.SPAN(1 << lv)) u_lvl (
      .gp_i (gp_s2[lv-HALF]),
      .gp_o (gp_s2[lv-HALF+1])
    );
  end

  assign carry     = {gp_s2[LEVELS-HALF].g | (gp_s2[LEVELS-HALF].p & {WIDTH{s1_data_q.cin}}),
                      s1_data_q.cin};
  assign diff_wrap = s1_data_q.p0 ^ carry[WIDTH-1:0];
  assign ovf_res   = (s1_data_q.a_msb ^ ~s1_data_q.bx_msb) & (diff_wrap[WIDTH-1] ^ s1_data_q.a_msb);

`ifdef KS16_SUB_SAT_EN
  always_comb begin
    diff_res = diff_wrap;
    if (ovf_res) begin
      diff_res = s1_data_q.a_msb ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign diff_res = diff_wrap;
`endif

  always_comb begin
    s2_valid_d = s2_valid_q;
    diff_d     = diff_q;
    bout_d     = bout_q;
    ovf_d      = ovf_q;
    zero_d     = zero_q;
    if (s2_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        diff_d = diff_res;
        bout_d = ~carry[WIDTH];
        ovf_d  = ovf_res;
        zero_d = (diff_res == '0);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      diff_q     <= '0;
      bout_q     <= 1'b0;
      ovf_q      <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      diff_q     <= diff_d;
      bout_q     <= bout_d;
      ovf_q      <= ovf_d;
      zero_q     <= zero_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
